pid_mc: RTL and testbench
=========================

Name: pid_mc

Overview:
Multi-channel, time-multiplexed PID controller that supersedes the single-channel PI engine. It serves N_CHAN independent control loops, each with its own gain bank and loop state, through one shared saturating Q-format multiplier. Requests arrive on a valid/ready input port and results leave on a single-cycle result pulse. It sits between the sensor front-end and the actuator drivers.

Parameters:
D_WIDTH, 16, data/coefficient width (signed two's complement)
Q_BITS, 13, fractional bits; 1.0 = 2^Q_BITS
N_CHAN, 4, number of channels (>=1)
LIM_MAX, 4096, upper saturation limit for output and integrator
LIM_MIN, -4096, lower saturation limit for output and integrator
CH_W (localparam), max(1, clog2(N_CHAN)), channel index width

Ports:
clk  in  1  clock
rstb  in  1  reset
cfg_we  in  1  config write strobe
cfg_chan  in  CH_W  config target channel
cfg_reg  in  2  0=kp, 1=ki, 2=kd, 3=clear channel state
cfg_data  in  D_WIDTH  signed coefficient
in_valid  in  1  request valid
in_ready  out  1  engine can accept a request
in_chan  in  CH_W  request channel
target  in  D_WIDTH  signed setpoint
measurement  in  D_WIDTH  signed process value
out_valid  out  1  result pulse, one cycle
out_chan  out  CH_W  channel of the result
out  out  D_WIDTH  signed saturated control output
out_sat  out  1  output was clamped this result

Behaviour:
- Reset: rstb is asynchronous and active-low; clock is clk. On reset, all of the following clear to 0: outputs, coefficients, per-channel prev_err/integ, and FSM state (IDLE).
- in_ready = (state==IDLE) && !cfg_we. It is combinational and is 1 out of reset. A request is accepted when in_valid && in_ready.
- Config writes are accepted in any state and take effect at the clock edge.
  - cfg_chan >= N_CHAN: write ignored.
  - cfg_reg 3: zeroes prev_err and integ of cfg_chan; cfg_data is ignored.
- Coefficients are snapshotted at acceptance. Gain writes never affect an in-flight iteration.
- Multiplier: full 2*D_WIDTH product, arithmetic shift right by Q_BITS (floor), then saturated to D_WIDTH. It never truncates.
- Internal sums are computed at D_WIDTH+2 bits, then saturated.
- FSM states: IDLE, P, I, D, OUT. One state per cycle. Request accepted at edge k.
  - Edge k (IDLE->P): latch chan. Latch e = sat_D(target - measurement). Latch kp/ki/kd.
  - P->I: acc = mul(kp, e).
  - I->D: it = clamp(integ[ch] + mul(ki, e), LIM_MIN, LIM_MAX). Write it to integ[ch] (anti-windup). acc += it.
  - D->OUT: acc += mul(kd, sat_D(e - prev_err[ch])). Write e to prev_err[ch].
  - OUT->IDLE, edge k+4: out = clamp(acc, LIM_MIN, LIM_MAX). out_sat = clamp active. out_chan = ch. out_valid = 1 for exactly one cycle.
- Latency: out_valid is high in the cycle after edge k+4. in_ready is high in that same cycle, so the peak rate is 1 result per 5 cycles.
- No output backpressure. out/out_chan/out_sat hold their values until the next result.
- in_chan >= N_CHAN: the request is accepted. The result is out=0, out_sat=0 with a normal out_valid pulse and unchanged loop state.
- Clear on the same edge as an in-flight write-back to the same channel: clear wins. Later write-backs of that iteration still occur.
- Channels are fully isolated; no state is shared except the multiplier.
- Reset mid-iteration aborts it: no out_valid pulse and all state cleared.

Optional Feature:
PID_DERIV_EN. When defined, the D state exists and the derivative is computed as above. When undefined:
- kd registers and prev_err storage are not instantiated.
- cfg_reg 2 is ignored.
- The FSM goes I->OUT, latency is 3 edges (out_valid after edge k+3), and the rate is 1 per 4 cycles.

Test Plan:
- Proportional: ch0 kp=8192, ki=kd=0; target=1000, meas=200 -> out=800, out_chan=0, out_sat=0, out_valid exactly after edge k+4.
- Output saturation: kp=16384 (2.0), target=3000, meas=0 -> out=4096, out_sat=1. Then target=-3000 -> out=-4096, out_sat=1.
- Integrator anti-windup, ch1 kp=kd=0, ki=8192: errors 3000, 3000, -1000 -> outs 3000, 4096 (out_sat=1), 3096.
- Derivative (PID_DERIV_EN), ch2 kd=8192 only: errors 100, 400, 400 -> outs 100, 300, 0. Without the macro: out always 0, latency 3.
- Isolation/clear: interleave ch1 (ki=8192, e=500) and ch3 (ki=8192, e=-200) -> ch1 outs 500, 1000 and ch3 outs -200, -400. Then cfg_reg=3 on ch1 and e=500 -> 500. cfg_we held high -> in_ready=0.
- Reset mid-operation: rstb low one cycle after acceptance -> no out_valid, out=0, in_ready=1 after release, next proportional request gives 0 (gains cleared).

Source files
------------

// File: rtl/pid_mc.sv
// pid_mc: multi-channel time-multiplexed PID engine with one shared
// saturating Q-format multiplier and per-channel gain/state banks.
// Optional derivative path enabled by defining PID_DERIV_EN; without it
// the FSM skips the D state and kd/prev_err storage is not built.
module pid_mc #(
    parameter int D_WIDTH = 16,
    parameter int Q_BITS  = 13,
    parameter int N_CHAN  = 4,
    parameter int LIM_MAX = 4096,
    parameter int LIM_MIN = -4096,
    localparam int CH_W   = (N_CHAN > 1) ? $clog2(N_CHAN) : 1
) (
    input  logic                      clk,
    input  logic                      rstb,
    input  logic                      cfg_we,
    input  logic [CH_W-1:0]           cfg_chan,
    input  logic [1:0]                cfg_reg,
    input  logic signed [D_WIDTH-1:0] cfg_data,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [CH_W-1:0]           in_chan,
    input  logic signed [D_WIDTH-1:0] target,
    input  logic signed [D_WIDTH-1:0] measurement,
    output logic                      out_valid,
    output logic [CH_W-1:0]           out_chan,
    output logic signed [D_WIDTH-1:0] out,
    output logic                      out_sat
);

    typedef logic signed [D_WIDTH-1:0]   data_t;
    typedef logic signed [D_WIDTH+1:0]   sum_t;
    typedef logic signed [2*D_WIDTH-1:0] prod_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_P,
        S_I,
`ifdef PID_DERIV_EN
        S_D,
`endif
        S_OUT
    } state_t;

    localparam data_t D_MAX = {1'b0, {(D_WIDTH-1){1'b1}}};
    localparam data_t D_MIN = {1'b1, {(D_WIDTH-1){1'b0}}};
    localparam prod_t P_MAX = {{(D_WIDTH+1){1'b0}}, {(D_WIDTH-1){1'b1}}};
    localparam prod_t P_MIN = {{(D_WIDTH+1){1'b1}}, {(D_WIDTH-1){1'b0}}};
    localparam sum_t  L_HI  = sum_t'(LIM_MAX);
    localparam sum_t  L_LO  = sum_t'(LIM_MIN);

    // Saturate any wide signed value to D_WIDTH.
    function automatic data_t sat_p(input prod_t x);
        if (x > P_MAX) return D_MAX;
        if (x < P_MIN) return D_MIN;
        return x[D_WIDTH-1:0];
    endfunction

    function automatic data_t sat_d(input sum_t x);
        return sat_p(prod_t'(x));
    endfunction

    // Full-width product, floor shift by Q_BITS, then saturate (never wraps).
    function automatic data_t mul_q(input data_t a, input data_t b);
        prod_t p;
        p = a * b;
        return sat_p(p >>> Q_BITS);
    endfunction

    function automatic sum_t clamp_lim(input sum_t x);
        if (x > L_HI) return L_HI;
        if (x < L_LO) return L_LO;
        return x;
    endfunction

    state_t          state_q, state_d;
    logic [CH_W-1:0] chan_q, chan_d;
    logic            chan_ok_q, chan_ok_d;
    data_t           e_q, e_d;
    data_t           kp_s_q, kp_s_d, ki_s_q, ki_s_d;
    sum_t            acc_q, acc_d;
    data_t           kp_q [N_CHAN];
    data_t           kp_d [N_CHAN];
    data_t           ki_q [N_CHAN];
    data_t           ki_d [N_CHAN];
    data_t           integ_q [N_CHAN];
    data_t           integ_d [N_CHAN];
`ifdef PID_DERIV_EN
    data_t           kd_s_q, kd_s_d;
    data_t           kd_q [N_CHAN];
    data_t           kd_d [N_CHAN];
    data_t           prev_err_q [N_CHAN];
    data_t           prev_err_d [N_CHAN];
    data_t           diff;
`endif
    data_t           out_q, out_d;
    logic [CH_W-1:0] out_chan_q, out_chan_d;
    logic            out_sat_q, out_sat_d;
    logic            out_valid_q, out_valid_d;

    data_t           mul_a, mul_b, mul_y;
    sum_t            it_w, acc_lim;
    logic [CH_W-1:0] rd_ix, in_ix;
    logic            in_ok, cfg_ok;

    assign in_ready  = (state_q == S_IDLE) && !cfg_we;
    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;
    assign out       = out_q;
    assign out_sat   = out_sat_q;

    // Shared multiplier; operands are steered by the FSM below.
    assign mul_y = mul_q(mul_a, mul_b);

    // Next-state, datapath and configuration updates.
    always_comb begin
        // NOTE: every signal written here gets a default first so no latch is inferred.
        state_d     = state_q;
        chan_d      = chan_q;
        chan_ok_d   = chan_ok_q;
        e_d         = e_q;
        kp_s_d      = kp_s_q;
        ki_s_d      = ki_s_q;
        acc_d       = acc_q;
        kp_d        = kp_q;
        ki_d        = ki_q;
        integ_d     = integ_q;
`ifdef PID_DERIV_EN
        kd_s_d      = kd_s_q;
        kd_d        = kd_q;
        prev_err_d  = prev_err_q;
        diff        = '0;
`endif
        out_d       = out_q;
        out_chan_d  = out_chan_q;
        out_sat_d   = out_sat_q;
        out_valid_d = 1'b0;
        mul_a       = '0;
        mul_b       = '0;
        it_w        = '0;
        acc_lim     = '0;
        in_ok       = int'(in_chan) < N_CHAN;
        in_ix       = in_ok ? in_chan : '0;
        rd_ix       = chan_ok_q ? chan_q : '0;
        cfg_ok      = int'(cfg_chan) < N_CHAN;

        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    state_d   = S_P;
                    chan_d    = in_chan;
                    chan_ok_d = in_ok;
                    e_d       = sat_d(sum_t'(target) - sum_t'(measurement));
                    kp_s_d    = kp_q[in_ix];
                    ki_s_d    = ki_q[in_ix];
`ifdef PID_DERIV_EN
                    kd_s_d    = kd_q[in_ix];
`endif
                end
            end
            S_P: begin
                mul_a   = kp_s_q;
                mul_b   = e_q;
                acc_d   = sum_t'(mul_y);
                state_d = S_I;
            end
            S_I: begin
                mul_a = ki_s_q;
                mul_b = e_q;
                it_w  = clamp_lim(sum_t'(integ_q[rd_ix]) + sum_t'(mul_y));
                if (chan_ok_q) integ_d[rd_ix] = it_w[D_WIDTH-1:0];
                acc_d = acc_q + it_w;
`ifdef PID_DERIV_EN
                state_d = S_D;
`else
                state_d = S_OUT;
`endif
            end
`ifdef PID_DERIV_EN
            S_D: begin
                diff  = sat_d(sum_t'(e_q) - sum_t'(prev_err_q[rd_ix]));
                mul_a = kd_s_q;
                mul_b = diff;
                acc_d = acc_q + sum_t'(mul_y);
                if (chan_ok_q) prev_err_d[rd_ix] = e_q;
                state_d = S_OUT;
            end
`endif
            S_OUT: begin
                acc_lim     = clamp_lim(acc_q);
                out_d       = chan_ok_q ? acc_lim[D_WIDTH-1:0] : '0;
                // Saturation flag means the output sits on a rail, including exactly reaching it.
                out_sat_d   = chan_ok_q && ((acc_q >= L_HI) || (acc_q <= L_LO));
                out_chan_d  = chan_q;
                out_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // Configuration is applied after write-backs so a clear wins a same-edge collision.
        if (cfg_we && cfg_ok) begin
            case (cfg_reg)
                2'd0: kp_d[cfg_chan] = cfg_data;
                2'd1: ki_d[cfg_chan] = cfg_data;
`ifdef PID_DERIV_EN
                2'd2: kd_d[cfg_chan] = cfg_data;
`endif
                2'd3: begin
                    integ_d[cfg_chan] = '0;
`ifdef PID_DERIV_EN
                    prev_err_d[cfg_chan] = '0;
`endif
                end
                default: ;
            endcase
        end
    end

    // State registers; reset clears everything, aborting any iteration in flight.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state_q     <= S_IDLE;
            chan_q      <= '0;
            chan_ok_q   <= 1'b0;
            e_q         <= '0;
            kp_s_q      <= '0;
            ki_s_q      <= '0;
            acc_q       <= '0;
            kp_q        <= '{default: '0};
            ki_q        <= '{default: '0};
            // NOTE: the small per-channel banks are reset because loop state must start at zero.
            integ_q     <= '{default: '0};
`ifdef PID_DERIV_EN
            kd_s_q      <= '0;
            kd_q        <= '{default: '0};
            prev_err_q  <= '{default: '0};
`endif
            out_q       <= '0;
            out_chan_q  <= '0;
            out_sat_q   <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            // NOTE: non-blocking so every flop samples pre-edge values.
            state_q     <= state_d;
            chan_q      <= chan_d;
            chan_ok_q   <= chan_ok_d;
            e_q         <= e_d;
            kp_s_q      <= kp_s_d;
            ki_s_q      <= ki_s_d;
            acc_q       <= acc_d;
            kp_q        <= kp_d;
            ki_q        <= ki_d;
            integ_q     <= integ_d;
`ifdef PID_DERIV_EN
            kd_s_q      <= kd_s_d;
            kd_q        <= kd_d;
            prev_err_q  <= prev_err_d;
`endif
            out_q       <= out_d;
            out_chan_q  <= out_chan_d;
            out_sat_q   <= out_sat_d;
            out_valid_q <= out_valid_d;
        end
    end

endmodule

// File: tb/tb_pid_mc.sv
// tb_pid_mc: directed stimulus for pid_mc with a scoreboard queue; a
// monitor pops expected results whenever out_valid pulses.
module tb_pid_mc;

    localparam int DW  = 16;
    localparam int CHW = 2;
`ifdef PID_DERIV_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 3;
`endif

    logic                 clk;
    logic                 rstb;
    logic                 cfg_we;
    logic [CHW-1:0]       cfg_chan;
    logic [1:0]           cfg_reg;
    logic signed [DW-1:0] cfg_data;
    logic                 in_valid;
    logic                 in_ready;
    logic [CHW-1:0]       in_chan;
    logic signed [DW-1:0] target;
    logic signed [DW-1:0] measurement;
    logic                 out_valid;
    logic [CHW-1:0]       out_chan;
    logic signed [DW-1:0] out;
    logic                 out_sat;

    typedef struct {
        int ch;
        int val;
        int sat;
        int cyc;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;

    pid_mc dut (
        .clk         (clk),
        .rstb        (rstb),
        .cfg_we      (cfg_we),
        .cfg_chan    (cfg_chan),
        .cfg_reg     (cfg_reg),
        .cfg_data    (cfg_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_chan     (in_chan),
        .target      (target),
        .measurement (measurement),
        .out_valid   (out_valid),
        .out_chan    (out_chan),
        .out         (out),
        .out_sat     (out_sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, exp);
        end
    endtask

    // Monitor: every result pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (rstb && out_valid) begin
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_result: pulse at cycle %0d, required none", cyc);
            end else begin
                mon_e = sb.pop_front();
                check("out", int'(out), mon_e.val);
                check("out_sat", int'(out_sat), mon_e.sat);
                check("out_chan", int'(out_chan), mon_e.ch);
                check("latency_cycle", cyc, mon_e.cyc);
                if (!cfg_we) check("in_ready_with_result", int'(in_ready), 1);
            end
        end
    end

    task automatic cfg(input int ch, input int rg, input int data);
        @(negedge clk);
        cfg_we   = 1'b1;
        cfg_chan = CHW'(ch);
        cfg_reg  = 2'(rg);
        cfg_data = DW'(data);
        @(negedge clk);
        cfg_we   = 1'b0;
    endtask

    task automatic send(input int ch, input int tgt, input int meas,
                        input bit expect_it, input int exp_out, input int exp_sat);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!in_ready && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!in_ready) begin
            n_checks++;
            n_errors++;
            $display("FAIL accept_timeout: in_ready low for %0d cycles, required high", waited);
            return;
        end
        in_chan     = CHW'(ch);
        target      = DW'(tgt);
        measurement = DW'(meas);
        in_valid    = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (expect_it) sb.push_back('{ch, exp_out, exp_sat, cyc + LAT});
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: %0d results outstanding, required 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rstb = 1'b0; cfg_we = 1'b0; cfg_chan = '0; cfg_reg = '0; cfg_data = '0;
        in_valid = 1'b0; in_chan = '0; target = '0; measurement = '0;
        repeat (3) @(negedge clk);
        rstb = 1'b1;
        @(negedge clk);
        check("reset_out", int'(out), 0);
        check("reset_out_valid", int'(out_valid), 0);
        check("reset_out_sat", int'(out_sat), 0);
        check("reset_out_chan", int'(out_chan), 0);
        check("reset_in_ready", int'(in_ready), 1);

        // Proportional and output saturation on ch0.
        cfg(0, 0, 8192);
        send(0, 1000, 200, 1, 800, 0);
        wait_idle();
        cfg(0, 0, 16384);
        send(0, 3000, 0, 1, 4096, 1);
        send(0, -3000, 0, 1, -4096, 1);
        wait_idle();

        // Floor rounding of the Q shift (0.5 * -3 -> -2, 0.5 * 3 -> 1).
        cfg(0, 0, 4096);
        send(0, -3, 0, 1, -2, 0);
        send(0, 3, 0, 1, 1, 0);
        wait_idle();

        // Error saturates to D_WIDTH before multiplying.
        cfg(0, 0, 1);
        send(0, 32767, -32768, 1, 3, 0);
        send(0, -32768, 32767, 1, -4, 0);
        wait_idle();

        // Multiplier saturates rather than wrapping.
        cfg(0, 0, 32767);
        send(0, 32767, -32768, 1, 4096, 1);
        wait_idle();

        // Gain snapshot: a write right after acceptance does not disturb it.
        cfg(0, 0, 8192);
        send(0, 1000, 200, 1, 800, 0);
        cfg(0, 0, 0);
        send(0, 1000, 200, 1, 0, 0);
        wait_idle();

        // Integrator anti-windup on ch1.
        cfg(1, 1, 8192);
        send(1, 3000, 0, 1, 3000, 0);
        send(1, 3000, 0, 1, 4096, 1);
        send(1, -1000, 0, 1, 3096, 0);
        wait_idle();

        // Derivative on ch2.
        cfg(2, 2, 8192);
`ifdef PID_DERIV_EN
        send(2, 100, 0, 1, 100, 0);
        send(2, 400, 0, 1, 300, 0);
        send(2, 400, 0, 1, 0, 0);
`else
        send(2, 100, 0, 1, 0, 0);
        send(2, 400, 0, 1, 0, 0);
        send(2, 400, 0, 1, 0, 0);
`endif
        wait_idle();

        // Isolation between ch1 and ch3, then clear of ch1.
        cfg(1, 3, 1234);
        cfg(3, 1, 8192);
        send(1, 500, 0, 1, 500, 0);
        send(3, 0, 200, 1, -200, 0);
        send(1, 500, 0, 1, 1000, 0);
        send(3, 0, 200, 1, -400, 0);
        wait_idle();
        cfg(1, 3, 0);
        send(1, 500, 0, 1, 500, 0);
        wait_idle();

        // Config strobe held high blocks acceptance.
        @(negedge clk);
        cfg_we = 1'b1; cfg_chan = 2'd3; cfg_reg = 2'd1; cfg_data = 16'sd8192;
        in_valid = 1'b1; in_chan = 2'd0; target = 16'sd1000; measurement = 16'sd0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("in_ready_cfg_we", int'(in_ready), 0);
            @(negedge clk);
        end
        cfg_we = 1'b0;
        in_valid = 1'b0;
        wait_idle();

        // Reset mid-iteration aborts it and clears gains.
        cfg(0, 0, 8192);
        send(0, 1000, 200, 0, 0, 0);
        @(negedge clk);
        rstb = 1'b0;
        @(negedge clk);
        rstb = 1'b1;
        #1;
        check("abort_out", int'(out), 0);
        check("abort_out_valid", int'(out_valid), 0);
        check("abort_in_ready", int'(in_ready), 1);
        repeat (8) @(negedge clk);
        send(0, 1000, 200, 1, 0, 0);
        wait_idle();

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
